// File: rtl/eth_rx_slot_ctrl.sv
// eth_rx_slot_ctrl: write-side sequencer and slot manager for a 4-slot 16b->64b RX frame buffer.
// MAC halfwords land in one of four 4 KB slots; good frames are queued in order, bad ones dropped.
// Optional feature: define ETH_RX_FCS_STRIP_EN to report lengths without the 4-byte FCS
// (frames of 4 bytes or less are then dropped and counted).
module eth_rx_slot_ctrl #(
  parameter int unsigned MAX_BYTES = 1536,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clka,
  input  logic             rst_int,
  input  logic             rx_valid_i,
  input  logic [15:0]      rx_data_i,
  input  logic             rx_last_i,
  input  logic             rx_odd_i,
  input  logic             rx_err_i,
  output logic [12:0]      mem_addra_o,
  output logic [15:0]      mem_dina_o,
  output logic [1:0]       mem_wea_o,
  output logic             mem_ena_o,
  output logic [10:0]      mem_addrb_o,
  output logic             mem_enb_o,
  output logic [1:0]       mem_web_o,
  input  logic [63:0]      mem_doutb_i,
  input  logic             host_rd_req_i,
  input  logic [8:0]       host_rd_word_i,
  output logic [63:0]      host_rd_data_o,
  output logic             host_rd_vld_o,
  output logic             frm_avail_o,
  output logic [1:0]       frm_slot_o,
  output logic [12:0]      frm_len_o,
  input  logic             frm_release_i,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam int unsigned MAX_HW = MAX_BYTES / 2;
  localparam int unsigned NSLOT  = 4;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t      state, state_n;
  logic [10:0] offset, offset_n;
  logic [1:0]  wr_slot, rd_slot, rd_slot_n;
  logic [2:0]  used, used_n;
  logic        commit_pend;
  logic [1:0]  commit_slot;
  logic [12:0] commit_len;
  logic [12:0] len_q [NSLOT];

  logic        wr_c, fin_c, commit_c, drop_c, full_c, release_c;
  logic [10:0] wr_off_c;
  logic [1:0]  we_c;
  logic [11:0] beats_c;
  logic [12:0] len_c, commit_len_c;

  assign mem_web_o      = 2'b00;
  assign host_rd_data_o = host_rd_vld_o ? mem_doutb_i : 64'd0;

  // Beat decode: decide write, commit or drop for the current MAC beat.
  always_comb begin
    state_n      = state;
    offset_n     = offset;
    wr_c         = 1'b0;
    fin_c        = 1'b0;
    commit_c     = 1'b0;
    drop_c       = 1'b0;
    wr_off_c     = offset;
    commit_len_c = 13'd0;
    // A commit still waiting to update 'used' already owns its slot.
    full_c       = (3'(used + 3'(commit_pend)) == 3'(NSLOT));
    release_c    = frm_release_i & frm_avail_o;
    we_c         = (rx_last_i & rx_odd_i) ? 2'b01 : 2'b11;
    case (state)
      IDLE: begin
        if (rx_valid_i) begin
          if (full_c) begin
            if (rx_last_i) drop_c = 1'b1;
            else           state_n = DROP;
          end else begin
            wr_c     = 1'b1;
            wr_off_c = 11'd0;
            offset_n = 11'd0;
            if (rx_last_i) fin_c = 1'b1;
            else           state_n = RECV;
          end
        end
      end
      RECV: begin
        if (rx_valid_i) begin
          if (offset == 11'(MAX_HW - 1)) begin
            if (rx_last_i) begin
              drop_c  = 1'b1;
              state_n = IDLE;
            end else begin
              state_n = DROP;
            end
          end else begin
            wr_c     = 1'b1;
            wr_off_c = offset + 11'd1;
            offset_n = offset + 11'd1;
            if (rx_last_i) begin
              fin_c   = 1'b1;
              state_n = IDLE;
            end
          end
        end
      end
      DROP: begin
        if (rx_valid_i && rx_last_i) begin
          drop_c  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    beats_c = 12'(wr_off_c) + 12'd1;
    len_c   = 13'({beats_c, 1'b0}) - 13'(rx_odd_i);
    if (fin_c) begin
      if (rx_err_i) begin
        drop_c = 1'b1;
      end else begin
`ifdef ETH_RX_FCS_STRIP_EN
        if (len_c <= 13'd4) begin
          drop_c = 1'b1;
        end else begin
          commit_c     = 1'b1;
          commit_len_c = len_c - 13'd4;
        end
`else
        commit_c     = 1'b1;
        commit_len_c = len_c;
`endif
      end
    end
    used_n    = 3'(used + 3'(commit_pend) - 3'(release_c));
    rd_slot_n = release_c ? rd_slot + 2'd1 : rd_slot;
  end

  // Receive FSM, slot/queue bookkeeping and all registered outputs.
  always_ff @(posedge clka or posedge rst_int) begin
    if (rst_int) begin
      state         <= IDLE;
      offset        <= 11'd0;
      wr_slot       <= 2'd0;
      rd_slot       <= 2'd0;
      used          <= 3'd0;
      commit_pend   <= 1'b0;
      commit_slot   <= 2'd0;
      commit_len    <= 13'd0;
      for (int i = 0; i < int'(NSLOT); i++) len_q[i] <= 13'd0;
      mem_addra_o   <= 13'd0;
      mem_dina_o    <= 16'd0;
      mem_wea_o     <= 2'b00;
      mem_ena_o     <= 1'b0;
      mem_addrb_o   <= 11'd0;
      mem_enb_o     <= 1'b0;
      host_rd_vld_o <= 1'b0;
      frm_avail_o   <= 1'b0;
      frm_slot_o    <= 2'd0;
      frm_len_o     <= 13'd0;
      drop_cnt_o    <= '0;
    end else begin
      state  <= state_n;
      offset <= offset_n;

      // Commit is staged one cycle so the descriptor appears after the last write.
      commit_pend <= commit_c;
      if (commit_c) begin
        wr_slot     <= wr_slot + 2'd1;
        commit_slot <= wr_slot;
        commit_len  <= commit_len_c;
      end
      if (commit_pend) len_q[commit_slot] <= commit_len;
      used    <= used_n;
      rd_slot <= rd_slot_n;

      frm_avail_o <= (used_n != 3'd0);
      frm_slot_o  <= rd_slot_n;
      if (used_n == 3'd0)
        frm_len_o <= 13'd0;
      else if (commit_pend && (commit_slot == rd_slot_n))
        frm_len_o <= commit_len;
      else
        frm_len_o <= len_q[rd_slot_n];

      if (drop_c && (drop_cnt_o != '1)) drop_cnt_o <= drop_cnt_o + 1'b1;

      mem_ena_o   <= wr_c;
      mem_wea_o   <= wr_c ? we_c : 2'b00;
      mem_addra_o <= {wr_slot, wr_off_c};
      mem_dina_o  <= rx_data_i;

      mem_enb_o     <= host_rd_req_i;
      mem_addrb_o   <= {rd_slot, host_rd_word_i};
      host_rd_vld_o <= mem_enb_o;
    end
  end

endmodule
